// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the FIR filter family.
// Round/saturate is reused by the decimator blocks.
package fir_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } fir_state_t;

  typedef struct packed {
    logic                    sat;
    logic signed [MAX_W-1:0] val;
  } rs_t;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int tpp
  );
    return dw + cw + $clog2(tpp) + 1;
  endfunction

  // Round half up by shift, then clamp to out_w signed.
  function automatic rs_t round_sat(
    input logic signed [MAX_W-1:0] acc,
    input int                      shift,
    input int                      out_w
  );
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    rs_t res;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    r   = acc;
    if (shift > 0)
      r = (acc + (one <<< (shift - 1))) >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -hi - one;
    res.sat = (r > hi) || (r < lo);
    if (r > hi)
      res.val = hi;
    else if (r < lo)
      res.val = lo;
    else
      res.val = r;
    return res;
  endfunction

endpackage

// File: rtl/fir_phase_mac.sv
// Combinational dot product of the delay line with one
// polyphase branch of the prototype filter.
module fir_phase_mac
  import fir_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int N_TAPS  = 16,
  parameter int L       = 4,
  parameter int ACC_W   = 34,
  parameter int TPP     = N_TAPS / L,
  parameter int PW      = $clog2(L)
) (
  input  logic [TPP-1:0][DATA_W-1:0]  x_i,
  input  logic [N_TAPS*COEFF_W-1:0]   coeff_i,
  input  logic [PW-1:0]               phase_i,
  output logic signed [ACC_W-1:0]     acc_o
);

  logic signed [DATA_W-1:0]  xs;
  logic signed [COEFF_W-1:0] cs;
  logic signed [ACC_W-1:0]   xe;
  logic signed [ACC_W-1:0]   ce;
  logic signed [ACC_W-1:0]   sum;

  // Branch p uses taps h[k*L+p]; the mux picks them per tap.
  always_comb begin
    sum = '0;
    xs  = '0;
    cs  = '0;
    xe  = '0;
    ce  = '0;
    for (int k = 0; k < TPP; k++) begin
      xs = x_i[k];
      cs = '0;
      for (int p = 0; p < L; p++) begin
        if (phase_i == PW'(p))
          cs = coeff_i[(k*L+p)*COEFF_W +: COEFF_W];
      end
      xe  = {{(ACC_W-DATA_W){xs[DATA_W-1]}}, xs};
      ce  = {{(ACC_W-COEFF_W){cs[COEFF_W-1]}}, cs};
      sum = sum + xe * ce;
    end
    acc_o = sum;
  end

endmodule

// File: rtl/fir_interp_polyphase.sv
// Polyphase interpolate-by-L FIR: one input sample yields
// L rounded, saturated outputs with valid/ready on both sides.
module fir_interp_polyphase
  import fir_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int N_TAPS  = 16,
  parameter int L       = 4,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 15
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [N_TAPS*COEFF_W-1:0]   coeff,
  input  logic signed [DATA_W-1:0]    data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic signed [OUT_W-1:0]     data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        sat_out
);

  localparam int TPP   = N_TAPS / L;
  localparam int ACC_W = acc_width(DATA_W, COEFF_W, TPP);
  localparam int PW    = $clog2(L);
  localparam logic [PW-1:0] LAST = PW'(L - 1);

  fir_state_t                 state_q, state_d;
  logic [PW-1:0]              phase_q, phase_d;
  logic [TPP-1:0][DATA_W-1:0] x_q, x_d;
  logic signed [OUT_W-1:0]    dout_q, dout_d;
  logic                       vout_q, vout_d;
  logic                       sat_q, sat_d;

  logic                       ld;
  logic                       last;
  logic                       accept;
  logic signed [ACC_W-1:0]    acc;
  logic signed [MAX_W-1:0]    acc_ext;
  rs_t                        rs;
  logic                       unused;

  fir_phase_mac #(
    .DATA_W  (DATA_W),
    .COEFF_W (COEFF_W),
    .N_TAPS  (N_TAPS),
    .L       (L),
    .ACC_W   (ACC_W),
    .TPP     (TPP),
    .PW      (PW)
  ) u_mac (
    .x_i     (x_q),
    .coeff_i (coeff),
    .phase_i (phase_q),
    .acc_o   (acc)
  );

  assign acc_ext = {{(MAX_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign rs      = round_sat(acc_ext, SHIFT, OUT_W);
  assign unused  = ^rs.val[MAX_W-1:OUT_W];

  assign ld     = (state_q == RUN) && (!vout_q || ready_in);
  assign last   = (phase_q == LAST);
  assign accept = valid_in && ready_out;

  // A new sample fits in IDLE or as the last phase leaves.
  assign ready_out = (state_q == IDLE)
                  || ((state_q == RUN) && last && ld);

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign sat_out   = sat_q;

  // Phase sequencing, output load/drain and delay-line shift.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    x_d     = x_q;
    dout_d  = dout_q;
    vout_d  = vout_q;
    sat_d   = sat_q;
    if (ld) begin
      dout_d  = rs.val[OUT_W-1:0];
      sat_d   = rs.sat;
      vout_d  = 1'b1;
      phase_d = phase_q + 1'b1;
      if (last) begin
        phase_d = '0;
        state_d = IDLE;
      end
    end else if (ready_in && vout_q) begin
      vout_d = 1'b0;
    end
    if (accept) begin
      for (int k = 1; k < TPP; k++)
        x_d[k] = x_q[k-1];
      x_d[0]  = data_in;
      phase_d = '0;
      state_d = RUN;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      x_q     <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fir_interp_polyphase.sv
// Directed bench for fir_interp_polyphase with a scoreboard
// fed from a behavioural polyphase model.
module tb_fir_interp_polyphase;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int NT  = 8;
  localparam int LL  = 4;
  localparam int OW  = 16;
  localparam int TPP = NT / LL;

  logic                  clk = 1'b0;
  logic                  arst_n = 1'b0;
  logic [NT*CW-1:0]      coeff_a;
  logic [NT*CW-1:0]      coeff_b;
  logic signed [DW-1:0]  data_in = '0;
  logic                  valid_in = 1'b0;
  logic                  ready_in = 1'b1;
  logic                  ready_a, valid_a, sat_a;
  logic                  ready_b, valid_b, sat_b;
  logic signed [OW-1:0]  dout_a, dout_b;

  always #5 clk = ~clk;

  fir_interp_polyphase #(
    .DATA_W(DW), .COEFF_W(CW), .N_TAPS(NT),
    .L(LL), .OUT_W(OW), .SHIFT(0)
  ) u_dut (
    .clk(clk), .arst_n(arst_n), .coeff(coeff_a),
    .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_a), .data_out(dout_a),
    .valid_out(valid_a), .ready_in(ready_in),
    .sat_out(sat_a)
  );

  fir_interp_polyphase #(
    .DATA_W(DW), .COEFF_W(CW), .N_TAPS(NT),
    .L(LL), .OUT_W(OW), .SHIFT(15)
  ) u_rnd (
    .clk(clk), .arst_n(arst_n), .coeff(coeff_b),
    .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_b), .data_out(dout_b),
    .valid_out(valid_b), .ready_in(ready_in),
    .sat_out(sat_b)
  );

  typedef struct {
    longint v;
    bit     s;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  longint loga[$];
  longint logb[$];
  longint mx[TPP];
  int     nchk = 0;
  int     nerr = 0;
  int     cyc = 0;
  bit     fired = 1'b0;
  int     imp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
  int     rnd[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NT*CW-1:0] h,
                                 input int p, input int sh);
    exp_t e;
    longint acc;
    logic signed [CW-1:0] c;
    acc = 0;
    for (int k = 0; k < TPP; k++) begin
      c = h[(k*LL+p)*CW +: CW];
      acc += mx[k] * longint'(c);
    end
    if (sh > 0)
      acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    e.v = acc;
    e.s = 1'b0;
    if (acc > 32767) begin
      e.v = 32767;
      e.s = 1'b1;
    end else if (acc < -32768) begin
      e.v = -32768;
      e.s = 1'b1;
    end
    return e;
  endfunction

  task automatic sample();
    exp_t e;
    @(negedge clk);
    fired = valid_in && ready_a;
    if (fired) begin
      for (int k = TPP - 1; k > 0; k--)
        mx[k] = mx[k-1];
      mx[0] = longint'(data_in);
      for (int p = 0; p < LL; p++) begin
        qa.push_back(model(coeff_a, p, 0));
        qb.push_back(model(coeff_b, p, 15));
      end
    end
    if (valid_a && ready_in) begin
      if (qa.size() == 0) begin
        chk("a_unexpected", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_data", longint'(dout_a), e.v);
        chk("a_sat", longint'(sat_a), longint'(e.s));
        loga.push_back(longint'(dout_a));
      end
    end
    if (valid_b && ready_in) begin
      if (qb.size() == 0) begin
        chk("b_unexpected", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_data", longint'(dout_b), e.v);
        chk("b_sat", longint'(sat_b), longint'(e.s));
        logb.push_back(longint'(dout_b));
      end
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic signed [DW-1:0] x);
    data_in  = x;
    valid_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fired) break;
    end
    if (!fired) chk("send_timeout", 0, 1);
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_log(input string tag, input longint q[$],
                         input int exp[12]);
    chk({tag, "_len"}, q.size(), 12);
    for (int i = 0; i < 12; i++)
      chk(tag, (i < q.size()) ? q[i] : -999999, exp[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nacc;
    int lastc;
    int first;
    foreach (mx[k]) mx[k] = 0;
    for (int i = 0; i < NT; i++) begin
      coeff_a[i*CW +: CW] = 16'(i + 1);
      coeff_b[i*CW +: CW] = (i == 0) ? 16'd1 : 16'd0;
    end

    #2;
    chk("rst_valid", valid_a, 0);
    chk("rst_data", dout_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_ready", ready_a, 1);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    tick();

    // Impulse through h = 1..8.
    loga.delete();
    send(16'sd1);
    send(16'sd0);
    send(16'sd0);
    drain(8);
    chk_log("impulse", loga, imp);
    chk("impulse_sat", sat_a, 0);

    // Saturation at both rails.
    for (int i = 0; i < NT; i++)
      coeff_a[i*CW +: CW] = 16'sd32767;
    send(16'sd32767);
    send(16'sd32767);
    drain(8);
    chk("sat_hi_data", dout_a, 32767);
    chk("sat_hi_flag", sat_a, 1);
    send(-16'sd32768);
    send(-16'sd32768);
    drain(8);
    chk("sat_lo_data", dout_a, -32768);
    chk("sat_lo_flag", sat_a, 1);

    // Rounding on the SHIFT=15 instance.
    for (int i = 0; i < NT; i++)
      coeff_a[i*CW +: CW] = 16'(i + 1);
    logb.delete();
    send(16'sd16384);
    send(16'sd16383);
    send(-16'sd16384);
    drain(8);
    chk_log("round", logb, rnd);

    // Backpressure after phase 1 is loaded.
    data_in  = 16'sd1;
    valid_in = 1'b1;
    tick();
    chk("bp_accept", fired, 1);
    valid_in = 1'b0;
    tick();
    tick();
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 16'sd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", valid_a, 1);
      chk("bp_hold",
          dout_a, (qa.size() > 0) ? qa[0].v : -999999);
      chk("bp_ready", ready_a, 0);
      chk("bp_noacc", fired, 0);
    end
    ready_in = 1'b1;
    send(16'sd2);
    drain(8);

    // Streaming with both sides always willing.
    nacc  = 0;
    lastc = -1;
    first = -1;
    ready_in = 1'b1;
    valid_in = 1'b1;
    data_in  = -16'sd7;
    for (int i = 0; i < 60 && nacc < 6; i++) begin
      tick();
      if (first >= 0) chk("stream_valid", valid_a, 1);
      if (fired) begin
        if (lastc >= 0) chk("stream_gap", cyc - lastc, LL);
        lastc = cyc;
        if (first < 0) first = cyc;
        nacc++;
        data_in = data_in + 16'sd5;
      end
    end
    chk("stream_count", nacc, 6);
    valid_in = 1'b0;
    drain(8);

    // Reset asserted while phase 2 is on the output.
    send(16'sd1);
    tick();
    tick();
    tick();
    arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_data", dout_a, 0);
    chk("mid_rst_sat", sat_a, 0);
    chk("mid_rst_ready", ready_a, 1);
    qa.delete();
    qb.delete();
    foreach (mx[k]) mx[k] = 0;
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    loga.delete();
    send(16'sd1);
    send(16'sd0);
    send(16'sd0);
    drain(8);
    chk_log("post_rst", loga, imp);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
